top_func3: RTL and testbench
============================

Name: top_func3

Overview:
- Three-input Boolean function unit for the binary-representations exercises.
- Evaluates F(A,B,C) from an 8-entry truth table indexed by {A,B,C}.
- F is combinational and valid with no clock activity.
- Adds a runtime-loadable truth-table register and a registered copy of F for use in clocked datapaths.
- Default function: F = A | (B & C), giving truth table 8'hF8 (bit i = F for {A,B,C} = i).

Parameters:
- DEFAULT_TABLE, 8'hF8, truth table used after reset and whenever the override is off; bit i is the F value for index i = {A,B,C}.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- A, input, 1, function input, MSB of the index.
- B, input, 1, function input, middle bit of the index.
- C, input, 1, function input, LSB of the index.
- cfg_we, input, 1, load cfg_table into the table register on the clock edge.
- cfg_table, input, 8, new truth-table value.
- cfg_sel, input, 1, 1 = use the loaded table register, 0 = use DEFAULT_TABLE.
- F, output, 1, combinational function result.
- F_q, output, 1, F registered, 1-cycle latency.
- minterm, output, 8, combinational one-hot decode of {A,B,C}.
- table_q, output, 8, current contents of the table register.

Behaviour:
- idx = {A,B,C}; minterm = 8'b1 << idx, combinational.
- active_table = cfg_sel ? table_q : DEFAULT_TABLE, combinational mux.
- F = active_table[idx], purely combinational, zero latency.
- F is independent of clk and rst_n whenever cfg_sel = 0. This requirement means F settles within one delta/propagation delay of any input change, even if the clock never toggles.
- Table register, on the rising clk edge:
  - if !rst_n, table_q <= DEFAULT_TABLE;
  - else if cfg_we, table_q <= cfg_table;
  - else hold.
- F_q, on the rising clk edge:
  - if !rst_n, F_q <= 0;
  - else F_q <= F, sampled from the pre-edge values of inputs and table.
- Reset values: table_q = DEFAULT_TABLE, F_q = 0.
- F and minterm have no reset value; they are combinational.
- Simultaneous cfg_we and cfg_sel = 1 on the same edge: F_q captures the old table's result. The new table affects F only after the edge.
- cfg_we asserted during reset: ignored, because reset wins.
- Reset asserted mid-operation: table_q returns to DEFAULT_TABLE on that edge. Any loaded table is lost.
- X/Z on A, B or C: no defined F. Out of scope.
- No handshake and no state machine.

Decomposition:
- Shared package top_func3_pkg holds:
  - localparam TABLE_W = 8 and IDX_W = 3;
  - localparam F_A_OR_BC = 8'hF8;
  - a typedef for the 8-bit truth table.
- One natural sub-module, top_func3_lut: a pure combinational 8:1 mux (table, idx -> F) plus the one-hot minterm decode.
- The top level holds the table register, the cfg_sel mux and the F_q register.

Test Plan:
- No clock, cfg_sel=0, {A,B,C}=3'b010, wait 5 ns -> F=0, minterm=8'h04.
- No clock, cfg_sel=0, sweep all 8 indices -> F = 0,0,0,1,1,1,1,1 for idx 0..7.
- Reset: rst_n=0 for 2 edges, then release -> table_q=8'hF8, F_q=0.
- Load table: cfg_we=1, cfg_table=8'h04 for 1 edge, then cfg_sel=1, {A,B,C}=3'b010 -> F=1 immediately, F_q=1 after the next edge.
- Same-edge load: cfg_sel=1, table_q=8'hF8, idx=2, cfg_we=1, cfg_table=8'hFF -> F_q=0 on that edge, F_q=1 on the following edge.
- Reset mid-operation after loading 8'h00 with cfg_sel=1, idx=7 -> after the reset edge table_q=8'hF8, F=1, F_q=0.

Source files
------------

// File: rtl/top_func3_pkg.sv
// Shared widths, default truth table and the truth-table type for top_func3.
package top_func3_pkg;

    localparam int unsigned TABLE_W = 8;
    localparam int unsigned IDX_W   = 3;

    typedef logic [TABLE_W-1:0] truth_table_t;

    // F = A | (B & C); bit i holds F for {A,B,C} = i.
    localparam truth_table_t F_A_OR_BC = 8'hF8;

endpackage

// File: rtl/top_func3_lut.sv
// Combinational 8:1 truth-table lookup plus one-hot minterm decode.
module top_func3_lut
    import top_func3_pkg::*;
(
    input  truth_table_t     table_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             f_o,
    output truth_table_t     minterm_o
);

    // Select the table bit addressed by the index and decode the index one-hot.
    always_comb begin
        f_o       = table_i[idx_i];
        minterm_o = TABLE_W'(1) << idx_i;
    end

endmodule

// File: rtl/top_func3.sv
// Three-input Boolean function unit with a loadable truth table and registered result.
module top_func3
    import top_func3_pkg::*;
#(
    parameter truth_table_t DEFAULT_TABLE = F_A_OR_BC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         A,
    input  logic         B,
    input  logic         C,
    input  logic         cfg_we,
    input  truth_table_t cfg_table,
    input  logic         cfg_sel,
    output logic         F,
    output logic         F_q,
    output truth_table_t minterm,
    output truth_table_t table_q
);

    logic [IDX_W-1:0] idx;
    truth_table_t     active_table;
    truth_table_t     table_d;
    logic             f_d;

    // Index is {A,B,C}; select the loaded table only when cfg_sel is high.
    always_comb begin
        idx          = {A, B, C};
        active_table = cfg_sel ? table_q : DEFAULT_TABLE;
    end

    top_func3_lut u_lut (
        .table_i   (active_table),
        .idx_i     (idx),
        .f_o       (F),
        .minterm_o (minterm)
    );

    // Next-state values: load on cfg_we, otherwise hold; F_q follows F.
    always_comb begin
        table_d = table_q;
        f_d     = F;
        if (cfg_we) begin
            table_d = cfg_table;
        end
    end

    // Table and result registers; reset overrides any pending load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            table_q <= DEFAULT_TABLE;
            F_q     <= 1'b0;
        end else begin
            table_q <= table_d;
            F_q     <= f_d;
        end
    end

endmodule

// File: tb/tb_top_func3.sv
// Directed bench for top_func3 with a per-cycle reference model and literal checks.
module tb_top_func3;

    logic       clk;
    logic       rst_n;
    logic       A, B, C;
    logic       cfg_we;
    logic [7:0] cfg_table;
    logic       cfg_sel;
    logic       F;
    logic       F_q;
    logic [7:0] minterm;
    logic [7:0] table_q;

    logic       clk_run;
    int         n_checks;
    int         n_fail;

    // Reference model state
    logic [7:0] m_table;
    logic       m_fq;
    logic       m_valid;
    logic       m_pre_f;

    top_func3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .C         (C),
        .cfg_we    (cfg_we),
        .cfg_table (cfg_table),
        .cfg_sel   (cfg_sel),
        .F         (F),
        .F_q       (F_q),
        .minterm   (minterm),
        .table_q   (table_q)
    );

    // Clock only runs once the no-clock phase is over.
    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Default function is A | (B & C); a loaded table is looked up by {A,B,C}.
    function automatic logic model_f(input logic a, input logic b, input logic c,
                                     input logic sel, input logic [7:0] t);
        int i;
        i = (a ? 4 : 0) + (b ? 2 : 0) + (c ? 1 : 0);
        if (!sel) return a | (b & c);
        return t[i];
    endfunction

    // Model update on every rising edge, using pre-edge inputs and table.
    always @(posedge clk) begin
        m_pre_f = model_f(A, B, C, cfg_sel, m_table);
        if (!rst_n) begin
            m_table = 8'hF8;
            m_fq    = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_fq = m_pre_f;
            if (cfg_we) m_table = cfg_table;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("minterm", minterm, 8'(1) << {A, B, C});
        if (m_valid) begin
            check("F", {7'd0, F}, {7'd0, model_f(A, B, C, cfg_sel, m_table)});
            check("table_q", table_q, m_table);
            check("F_q", {7'd0, F_q}, {7'd0, m_fq});
        end else if (!cfg_sel) begin
            check("F_prereset", {7'd0, F}, {7'd0, model_f(A, B, C, 1'b0, 8'h00)});
        end
    end

    task automatic drive(input logic we, input logic [7:0] tbl, input logic sel,
                         input logic [2:0] idx, input logic rn);
        @(negedge clk);
        #1;
        cfg_we    = we;
        cfg_table = tbl;
        cfg_sel   = sel;
        {A, B, C} = idx;
        rst_n     = rn;
    endtask

    initial begin
        logic [7:0] sweep_exp;
        n_checks  = 0;
        n_fail    = 0;
        clk_run   = 1'b0;
        m_valid   = 1'b0;
        m_table   = 8'h00;
        m_fq      = 1'b0;
        rst_n     = 1'b1;
        cfg_we    = 1'b0;
        cfg_table = 8'h00;
        cfg_sel   = 1'b0;
        {A, B, C} = 3'b010;

        // No clock: combinational path only.
        #5;
        check("noclk_F_010", {7'd0, F}, 8'h00);
        check("noclk_minterm_010", minterm, 8'h04);
        sweep_exp = 8'b1111_1000;
        for (int i = 0; i < 8; i++) begin
            {A, B, C} = 3'(i);
            #1;
            check("sweep_F", {7'd0, F}, {7'd0, sweep_exp[i]});
            check("sweep_minterm", minterm, 8'(1) << i);
        end

        // Reset for two edges, then release.
        rst_n     = 1'b0;
        {A, B, C} = 3'b000;
        clk_run   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        drive(1'b0, 8'h00, 1'b0, 3'b000, 1'b1);
        check("rst_table_q", table_q, 8'hF8);
        check("rst_F_q", {7'd0, F_q}, 8'h00);

        // Load 8'h04, then select it with idx 2.
        drive(1'b1, 8'h04, 1'b0, 3'b000, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 3'b010, 1'b1);
        #1;
        check("load_F", {7'd0, F}, 8'h01);
        @(posedge clk);
        #1;
        check("load_F_q", {7'd0, F_q}, 8'h01);

        // Same-edge load while selected: F_q sees the old table first.
        drive(1'b1, 8'hF8, 1'b0, 3'b010, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 3'b010, 1'b1);
        drive(1'b1, 8'hFF, 1'b1, 3'b010, 1'b1);
        @(posedge clk);
        #1;
        check("same_edge_F_q_old", {7'd0, F_q}, 8'h00);
        check("same_edge_table_q", table_q, 8'hFF);
        check("same_edge_F_new", {7'd0, F}, 8'h01);
        drive(1'b0, 8'h00, 1'b1, 3'b010, 1'b1);
        @(posedge clk);
        #1;
        check("same_edge_F_q_new", {7'd0, F_q}, 8'h01);

        // Reset mid-operation after loading 8'h00 with idx 7.
        drive(1'b1, 8'h00, 1'b1, 3'b111, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 3'b111, 1'b1);
        #1;
        check("mid_F_before", {7'd0, F}, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 3'b111, 1'b0);
        @(posedge clk);
        #1;
        check("mid_rst_table_q", table_q, 8'hF8);
        check("mid_rst_F", {7'd0, F}, 8'h01);
        check("mid_rst_F_q", {7'd0, F_q}, 8'h00);

        // Get F_q high, then reset with cfg_we asserted: reset wins.
        drive(1'b0, 8'h00, 1'b1, 3'b111, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_F_q", {7'd0, F_q}, 8'h01);
        drive(1'b1, 8'h55, 1'b1, 3'b111, 1'b0);
        @(posedge clk);
        #1;
        check("we_in_rst_table_q", table_q, 8'hF8);
        check("we_in_rst_F_q", {7'd0, F_q}, 8'h00);

        // Mixed traffic checked by the per-cycle model.
        for (int k = 0; k < 40; k++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), (k % 13) != 7);
        end
        drive(1'b0, 8'h00, 1'b0, 3'b000, 1'b1);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
